// File: rtl/huffman_encoder.sv
// huffman_encoder: JPEG luminance AC (run, category) symbols -> packed MSB-first
// code words, with a 1-padded flush of the final partial word on a `son` symbol.
module huffman_encoder #(
  parameter int WB_BIT  = 32,
  parameter int RUN_BIT = 4,
  parameter int CAT_BIT = 4
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [RUN_BIT-1:0] hk_run_i,
  input  logic [CAT_BIT-1:0] hk_cat_i,
  input  logic               hk_son_i,
  input  logic               hk_gecerli_i,
  output logic               hk_hazir_o,
  output logic [WB_BIT-1:0]  m_veri_o,
  output logic               m_gecerli_o,
  input  logic               m_hazir_i,
  output logic               hata_o
);

  localparam int ACC_W = 2 * WB_BIT;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int SYM_W = RUN_BIT + CAT_BIT;
  localparam int NSYM  = 1 << SYM_W;

  // Canonical Huffman definition of the luminance AC table: number of codes of
  // each length 1..16 (length 1 in the top byte), then the symbols in code order.
  localparam logic [16*8-1:0] BITS_PK = {
    8'd0, 8'd2, 8'd1, 8'd3, 8'd3, 8'd2, 8'd4, 8'd3,
    8'd5, 8'd5, 8'd4, 8'd4, 8'd0, 8'd0, 8'd1, 8'd125
  };
  localparam logic [162*8-1:0] HUFFVAL_PK = {
    8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h11, 8'h05, 8'h12,
    8'h21, 8'h31, 8'h41, 8'h06, 8'h13, 8'h51, 8'h61, 8'h07,
    8'h22, 8'h71, 8'h14, 8'h32, 8'h81, 8'h91, 8'ha1, 8'h08,
    8'h23, 8'h42, 8'hb1, 8'hc1, 8'h15, 8'h52, 8'hd1, 8'hf0,
    8'h24, 8'h33, 8'h62, 8'h72, 8'h82, 8'h09, 8'h0a, 8'h16,
    8'h17, 8'h18, 8'h19, 8'h1a, 8'h25, 8'h26, 8'h27, 8'h28,
    8'h29, 8'h2a, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
    8'h3a, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49,
    8'h4a, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59,
    8'h5a, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69,
    8'h6a, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78, 8'h79,
    8'h7a, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89,
    8'h8a, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96, 8'h97, 8'h98,
    8'h99, 8'h9a, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6, 8'ha7,
    8'ha8, 8'ha9, 8'haa, 8'hb2, 8'hb3, 8'hb4, 8'hb5, 8'hb6,
    8'hb7, 8'hb8, 8'hb9, 8'hba, 8'hc2, 8'hc3, 8'hc4, 8'hc5,
    8'hc6, 8'hc7, 8'hc8, 8'hc9, 8'hca, 8'hd2, 8'hd3, 8'hd4,
    8'hd5, 8'hd6, 8'hd7, 8'hd8, 8'hd9, 8'hda, 8'he1, 8'he2,
    8'he3, 8'he4, 8'he5, 8'he6, 8'he7, 8'he8, 8'he9, 8'hea,
    8'hf1, 8'hf2, 8'hf3, 8'hf4, 8'hf5, 8'hf6, 8'hf7, 8'hf8,
    8'hf9, 8'hfa
  };

  // Returns {length[4:0], code[15:0]} (code right-aligned) for one symbol by
  // walking the canonical code assignment. Length 0 marks a symbol with no code.
  function automatic logic [20:0] lut_entry(input int sym);
    logic [20:0] r;
    int code;
    int k;
    int nb;
    r    = '0;
    code = 0;
    k    = 0;
    for (int l = 1; l <= 16; l++) begin
      nb = int'(BITS_PK[(16-l)*8 +: 8]);
      for (int j = 0; j < nb; j++) begin
        if (int'(HUFFVAL_PK[(161-k)*8 +: 8]) == sym) r = {5'(l), 16'(code)};
        code = code + 1;
        k    = k + 1;
      end
      code = code << 1;
    end
    return r;
  endfunction

  logic [20:0] lut_w [NSYM];

  genvar gi;
  generate
    for (gi = 0; gi < NSYM; gi++) begin : g_lut
      localparam logic [20:0] ENT = lut_entry(gi);
      assign lut_w[gi] = ENT;
    end
  endgenerate

  typedef enum logic {CALIS, BOSALT} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_x;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_x;
  logic [WB_BIT-1:0]  out_q, out_d;
  logic               vld_q, vld_d;
  logic               hata_q, hata_d;

  logic [20:0]        ent_w;
  logic [4:0]         len_w;
  logic [15:0]        code_al_w;
  logic               slot_free_w;
  logic               extract_w;
  logic               accept_w;

  assign ent_w       = lut_w[{hk_run_i, hk_cat_i}];
  assign len_w       = ent_w[20:16];
  // Left-align the code inside 16 bits so its first bit sits at bit 15.
  assign code_al_w   = ent_w[15:0] << (5'd16 - len_w);
  assign slot_free_w = !vld_q || m_hazir_i;
  assign extract_w   = (cnt_q >= CNT_W'(WB_BIT)) && slot_free_w;
  assign hk_hazir_o  = (state_q == CALIS) && (cnt_q <= CNT_W'(ACC_W - 16));
  assign accept_w    = hk_gecerli_i && hk_hazir_o;

  assign m_veri_o    = out_q;
  assign m_gecerli_o = vld_q;
  assign hata_o      = hata_q;

  // Next-state: extract a full word, append an accepted code after it, run the flush FSM.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    vld_d   = vld_q && !m_hazir_i;
    hata_d  = hata_q;
    acc_x   = acc_q;
    cnt_x   = cnt_q;

    if (extract_w) begin
      out_d = acc_q[ACC_W-1 -: WB_BIT];
      vld_d = 1'b1;
      acc_x = acc_q << WB_BIT;
      cnt_x = cnt_q - CNT_W'(WB_BIT);
    end
    acc_d = acc_x;
    cnt_d = cnt_x;

    case (state_q)
      CALIS: begin
        if (accept_w) begin
          if (len_w != 5'd0) begin
            acc_d = acc_x | ({code_al_w, {(ACC_W-16){1'b0}}} >> cnt_x);
            cnt_d = cnt_x + CNT_W'(len_w);
          end else begin
            hata_d = 1'b1;
          end
          if (hk_son_i) state_d = BOSALT;
        end
      end
      BOSALT: begin
        if (cnt_q == '0) begin
          state_d = CALIS;
        end else if ((cnt_q < CNT_W'(WB_BIT)) && slot_free_w) begin
          // Partial word: keep the valid bits, pad everything after them with 1s.
          out_d   = acc_q[ACC_W-1 -: WB_BIT] | ({WB_BIT{1'b1}} >> cnt_q);
          vld_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALIS;
        end
      end
      default: state_d = CALIS;
    endcase
  end

  // State registers with asynchronous discard of all pending bits on reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= CALIS;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      hata_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      hata_q  <= hata_d;
    end
  end

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed bench for huffman_encoder: hand-computed code words for each scenario.
module tb_huffman_encoder;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [3:0]  hk_run_i;
  logic [3:0]  hk_cat_i;
  logic        hk_son_i;
  logic        hk_gecerli_i;
  logic        hk_hazir_o;
  logic [31:0] m_veri_o;
  logic        m_gecerli_o;
  logic        m_hazir_i;
  logic        hata_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] words[$];

  huffman_encoder #(.WB_BIT(32), .RUN_BIT(4), .CAT_BIT(4)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .hk_run_i     (hk_run_i),
    .hk_cat_i     (hk_cat_i),
    .hk_son_i     (hk_son_i),
    .hk_gecerli_i (hk_gecerli_i),
    .hk_hazir_o   (hk_hazir_o),
    .m_veri_o     (m_veri_o),
    .m_gecerli_o  (m_gecerli_o),
    .m_hazir_i    (m_hazir_i),
    .hata_o       (hata_o)
  );

  always #5 clk_i = ~clk_i;

  // Record each output word that will be taken at the next rising edge.
  always @(negedge clk_i) begin
    if (rstn_i && m_gecerli_o && m_hazir_i) begin
      words.push_back(m_veri_o);
      $display("[TB] word 0x%08h", m_veri_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Present one symbol and hold it until accepted (bounded wait).
  task automatic send(input logic [3:0] run, input logic [3:0] cat, input logic son);
    logic ok;
    ok           = 1'b0;
    hk_run_i     = run;
    hk_cat_i     = cat;
    hk_son_i     = son;
    hk_gecerli_i = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk_i);
      if (hk_hazir_o) begin
        @(posedge clk_i);
        #1;
        ok = 1'b1;
      end
    end
    hk_gecerli_i = 1'b0;
    hk_son_i     = 1'b0;
    $display("[TB] symbol %0d/%0d son=%0b accepted=%0b", run, cat, son, ok);
    check("sym_accept", {31'd0, ok}, 32'd1);
  endtask

  // Wait (bounded) until at least n words have been collected, then check the count.
  task automatic wait_words(input string tag, input int n);
    for (int c = 0; c < 100; c++) begin
      if (words.size() >= n) break;
      tick(1);
    end
    check(tag, 32'(words.size()), 32'(n));
  endtask

  int n_acc;

  initial begin
    rstn_i       = 1'b0;
    hk_run_i     = '0;
    hk_cat_i     = '0;
    hk_son_i     = 1'b0;
    hk_gecerli_i = 1'b0;
    m_hazir_i    = 1'b1;

    // Reset values
    tick(2);
    check("rst_hazir", {31'd0, hk_hazir_o}, 32'd1);
    check("rst_gecerli", {31'd0, m_gecerli_o}, 32'd0);
    check("rst_veri", m_veri_o, 32'h0);
    check("rst_hata", {31'd0, hata_o}, 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick(1);

    // Basic packing: 1010 01 00 1111111110000010 11010 100
    send(4'd0, 4'd0, 1'b0);
    send(4'd0, 4'd2, 1'b0);
    send(4'd0, 4'd1, 1'b0);
    send(4'd0, 4'd9, 1'b0);
    send(4'd0, 4'd5, 1'b0);
    send(4'd0, 4'd3, 1'b0);
    wait_words("basic_count", 1);
    tick(2);
    if (words.size() > 0) check("basic_word", words[0], 32'hA4FF82D4);
    check("basic_cnt", 32'(dut.cnt_q), 32'd0);
    check("basic_hata", {31'd0, hata_o}, 32'd0);
    words.delete();

    // Flush padding: 00 + 30 ones
    send(4'd0, 4'd1, 1'b1);
    check("flush_hazir_low", {31'd0, hk_hazir_o}, 32'd0);
    wait_words("flush_count", 1);
    tick(1);
    if (words.size() > 0) check("flush_word", words[0], 32'h3FFFFFFF);
    check("flush_hazir_back", {31'd0, hk_hazir_o}, 32'd1);
    words.delete();

    // Back-pressure: 0/10 streamed with the sink stalled
    m_hazir_i    = 1'b0;
    hk_run_i     = 4'd0;
    hk_cat_i     = 4'd10;
    hk_son_i     = 1'b0;
    hk_gecerli_i = 1'b1;
    n_acc        = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (hk_hazir_o) n_acc++;
      @(posedge clk_i);
      #1;
    end
    hk_gecerli_i = 1'b0;
    $display("[TB] backpressure accepted %0d symbols", n_acc);
    check("bp_accepted", 32'(n_acc), 32'd6);
    check("bp_hazir_low", {31'd0, hk_hazir_o}, 32'd0);
    check("bp_cnt", 32'(dut.cnt_q), 32'd64);
    check("bp_gecerli", {31'd0, m_gecerli_o}, 32'd1);
    check("bp_veri", m_veri_o, 32'hFF83FF83);
    tick(3);
    check("bp_veri_stable", m_veri_o, 32'hFF83FF83);
    m_hazir_i = 1'b1;
    wait_words("bp_count", 3);
    tick(2);
    for (int i = 0; i < 3 && i < words.size(); i++) check("bp_word", words[i], 32'hFF83FF83);
    check("bp_hazir_back", {31'd0, hk_hazir_o}, 32'd1);
    check("bp_cnt_end", 32'(dut.cnt_q), 32'd0);
    words.delete();

    // Invalid symbol, then ZRL with son: 11111111001 + 21 ones
    send(4'd1, 4'd0, 1'b0);
    check("inv_hata", {31'd0, hata_o}, 32'd1);
    check("inv_cnt", 32'(dut.cnt_q), 32'd0);
    send(4'd15, 4'd0, 1'b1);
    wait_words("zrl_count", 1);
    if (words.size() > 0) check("zrl_word", words[0], 32'hFF3FFFFF);
    check("zrl_hata", {31'd0, hata_o}, 32'd1);
    words.delete();

    // Word-aligned son: exactly one word, no padding word
    send(4'd0, 4'd9, 1'b0);
    send(4'd0, 4'd9, 1'b1);
    wait_words("align_first", 1);
    tick(6);
    check("align_count", 32'(words.size()), 32'd1);
    if (words.size() > 0) check("align_word", words[0], 32'hFF82FF82);
    check("align_hazir", {31'd0, hk_hazir_o}, 32'd1);
    words.delete();

    // Reset mid-stream: partial 0/8 must vanish without a clock edge
    send(4'd0, 4'd8, 1'b0);
    check("mid_cnt_before", 32'(dut.cnt_q), 32'd10);
    rstn_i = 1'b0;
    #2;
    check("mid_rst_cnt", 32'(dut.cnt_q), 32'd0);
    check("mid_rst_veri", m_veri_o, 32'h0);
    check("mid_rst_gecerli", {31'd0, m_gecerli_o}, 32'd0);
    check("mid_rst_hata", {31'd0, hata_o}, 32'd0);
    check("mid_rst_hazir", {31'd0, hk_hazir_o}, 32'd1);
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick(1);
    words.delete();
    send(4'd0, 4'd1, 1'b1);
    wait_words("mid_count", 1);
    if (words.size() > 0) check("mid_word", words[0], 32'h3FFFFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/huffman_encoder.md
# huffman_encoder

Entropy-coding stage of the JPEG encoder path and the counterpart of `huffman_decoder`. It accepts (run, category) symbols over a valid/ready handshake and looks up the JPEG Annex K luminance AC Huffman code (Table K.5). It packs the codes MSB-first into `WB_BIT`-wide words and emits them over a second valid/ready handshake. On a `son` marker it flushes the final partial word, padded with 1s. Byte stuffing (0xFF→0xFF00) is done downstream, not here.

## Interface
- `WB_BIT`, 32 (from `sabitler.vh`): output word width.
- `RUN_BIT`, 4 (from `sabitler.vh`): run-length field width.
- `CAT_BIT`, 4 (from `sabitler.vh`): category field width.
- `clk_i  input  1`: single clock, all state updates on the rising edge.
- `rstn_i  input  1`: asynchronous, active-low reset.
- `hk_run_i  input  RUN_BIT`: zero-run of the symbol.
- `hk_cat_i  input  CAT_BIT`: amplitude category of the symbol.
- `hk_son_i  input  1`: this symbol is the last of the segment; flush after it.
- `hk_gecerli_i  input  1`: symbol valid.
- `hk_hazir_o  output  1`: symbol ready.
- `m_veri_o  output  WB_BIT`: packed code word; the first code bit is in bit `WB_BIT-1`.
- `m_gecerli_o  output  1`: word valid.
- `m_hazir_i  input  1`: word ready.
- `hata_o  output  1`: sticky flag for an invalid symbol.

## Operation
- **Table**
  - Full Table K.5: 162 valid codes, lengths 2..16.
  - Run 0 codes: 0/0 (EOB) = 1010; 0/1 = 00; 0/2 = 01; 0/3 = 100; 0/4 = 1011; 0/5 = 11010; 0/6 = 1111000; 0/7 = 11111000; 0/8 = 1111110110; 0/9 = 1111111110000010; 0/10 = 1111111110000011.
  - ZRL 15/0 = 11111111001.
  - Invalid symbols: cat = 0 with run 1..14, or cat > 10. On accepting one: no bits appended, `hata_o` set, and it stays 1 until reset.
- **Storage**
  - `acc[2*WB_BIT-1:0]`: bits are MSB-aligned; the next free position is `2*WB_BIT-1-cnt`.
  - `cnt`: 7 bits, range 0..64.
  - One output register drives `m_veri_o` / `m_gecerli_o`.
- **Per-cycle actions**
  - Extract when `cnt >= WB_BIT` and (`!m_gecerli_o || m_hazir_i`): `acc[63:32]` loads the output register, `acc` shifts left by 32, and `cnt` decreases by 32.
  - Append happens on an accepted symbol (`hk_gecerli_i && hk_hazir_o`). The code is placed after the post-extraction `cnt`, and `cnt` increases by the code length.
  - Extract and append in the same cycle are both performed.
  - The output register clears `m_gecerli_o` on handshake unless reloaded in the same cycle.
- **State machine: CALIS ↔ BOSALT**
  - CALIS: `hk_hazir_o = (cnt <= 48)`.
  - An accepted symbol with `hk_son_i = 1` appends its code, then moves to BOSALT.
  - BOSALT: `hk_hazir_o = 0`. Full words drain by normal extraction.
  - When `0 < cnt < 32` and the output slot is free: emit `acc[63:32]` with bits below position 63-cnt forced to 1, set `cnt = 0`, and return to CALIS.
  - When `cnt == 0` and no full word remains: return to CALIS with no extra word. This covers the case where the `son` symbol is invalid or the stream is already word-aligned.

## Timing
- Reset values: `acc` = 0, `cnt` = 0, state = CALIS, `m_veri_o` = 0, `m_gecerli_o` = 0, `hata_o` = 0. `hk_hazir_o` = 1 while in reset and after it.
- `hk_hazir_o` is combinational from state and `cnt` only. It does not depend on `hk_gecerli_i` or `m_hazir_i`.
- Latency: if the symbol accepted at edge N makes `cnt >= 32`, `m_gecerli_o` rises after edge N+1 (output slot free).
- Flush latency: the padded word is valid 1 cycle after BOSALT is entered with `cnt < 32` and the slot free.
- Output stability: while `m_gecerli_o && !m_hazir_i`, `m_veri_o` holds stable.
- Throughput: 1 symbol per cycle when `m_hazir_i = 1`.
- Overflow: `cnt` never exceeds 64, because a symbol is accepted only at `cnt <= 48` and codes are at most 16 bits.
- Reset asserted mid-operation: partial bits and any pending word are discarded immediately, without waiting for a clock edge. `hata_o` clears.

## Test plan
- **Basic packing:** symbols 0/0, 0/2, 0/1, 0/9, 0/5, 0/3 back-to-back, `son = 0`, `m_hazir_i = 1` → one word `0xA4FF82D4`, `cnt = 0` afterwards, `hata_o = 0`.
- **Flush padding:** single symbol 0/1 with `son = 1` → word `0x3FFFFFFF`. `hk_hazir_o` is low during BOSALT and returns to 1 after the word's handshake.
- **Back-pressure:** `m_hazir_i = 0`, stream 0/10 continuously.
  - Exactly 6 symbols are accepted, then `hk_hazir_o = 0` with `cnt = 64`.
  - `m_veri_o = 0xFF83FF83` stays stable.
  - After `m_hazir_i = 1`: three words `0xFF83FF83` are received, then `hk_hazir_o` returns to 1.
- **Invalid symbol and ZRL:** 1/0 → `hata_o` = 1, `cnt` unchanged. Then 15/0 with `son = 1` → word `0xFF3FFFFF` (11111111001 followed by 21 ones). `hata_o` stays 1.
- **Word-aligned son:** 0/9, 0/9 with `son` on the second symbol → exactly one word `0xFF82FF82` and no pad word.
- **Reset mid-stream:** 0/8 accepted, then `rstn_i` pulsed low → all outputs at reset values. A following 0/1 with `son` yields `0x3FFFFFFF` with no residue of the earlier code.
